snoopy_bus_memory_responder: RTL and testbench
==============================================

Name: snoopy_bus_memory_responder

Overview:
Shared-bus slave at the far end of the cache controllers' master word interface. It services BUS_READ word fetches and BUS_WRITEBACK word stores issued by whichever cache holds the bus grant, using a 4-phase enable/functionComplete handshake. On a BUS_READ it defers to a snooping cache that hits (cache-to-cache intervention) and forwards that cache's word instead of its own. Sits between the bus arbiter/mux and backing storage.

Parameters:
ADDRESS_WIDTH, 8, word address width; storage depth = 2**ADDRESS_WIDTH words
DATA_WIDTH, 16, word width
READ_LATENCY, 2, cycles from accepted read to functionComplete when no intervention occurs (min 1)
WRITE_LATENCY, 1, cycles from accepted write to functionComplete (min 1)
LATENCY_WIDTH, 4, width of the latency counter; READ_LATENCY and WRITE_LATENCY must be < 2**LATENCY_WIDTH

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
busCommand  input  busCommands width  current bus command (NONE, BUS_READ, BUS_WRITEBACK, BUS_INVALIDATE)
address  input  ADDRESS_WIDTH  word address from the bus master
dataOut  input  DATA_WIDTH  write data from the master
readEnabled  input  1  master read request
writeEnabled  input  1  master write request
dataIn  output  DATA_WIDTH  read data to the master
functionComplete  output  1  handshake completion
snoopyHit  input  1  OR of all snooping caches' hits on the current address
snoopyFunctionComplete  input  1  intervening cache has its word on snoopyData
snoopyData  input  DATA_WIDTH  intervention word
protocolError  output  1  sticky; set on an illegal request combination

Behaviour:
- Reset (reset==0, async): state IDLE, functionComplete=0, dataIn=0, protocolError=0, counter=0. Storage contents are not reset. A reset mid-operation aborts with no storage write.
- States: IDLE, READ_WAIT, SNOOP_WAIT, WRITE_WAIT, COMPLETE.
- IDLE:
  - writeEnabled & busCommand==BUS_WRITEBACK -> latch address and data, counter=0, go to WRITE_WAIT.
  - Else readEnabled & busCommand==BUS_READ -> latch address; go to SNOOP_WAIT if snoopyHit, else READ_WAIT.
  - readEnabled & writeEnabled together -> protocolError=1 and the write wins.
  - Enable with busCommand NONE or BUS_INVALIDATE -> ignored; no error.
- READ_WAIT:
  - Counter increments each cycle.
  - snoopyHit rising before completion -> go to SNOOP_WAIT (intervention overrides memory).
  - When counter==READ_LATENCY-1: dataIn=mem[addr], functionComplete=1, go to COMPLETE.
  - Total: functionComplete is visible READ_LATENCY cycles after the accepting edge.
- SNOOP_WAIT:
  - On snoopyFunctionComplete: dataIn=snoopyData, functionComplete=1, go to COMPLETE.
  - No timeout. If snoopyHit drops without a completion, fall back to READ_WAIT with counter=0.
- WRITE_WAIT: when counter==WRITE_LATENCY-1, write mem[addr]=data, functionComplete=1, go to COMPLETE.
- COMPLETE:
  - Hold functionComplete and dataIn until readEnabled==0 && writeEnabled==0.
  - Then drop functionComplete on the next edge and return to IDLE. Back-to-back requests therefore need at least one idle cycle.
- Abort: if the requesting enable drops in READ_WAIT, WRITE_WAIT or SNOOP_WAIT, go to IDLE with no completion and no storage write.
- Address and data are sampled only at acceptance; changes afterwards are ignored.
- Read-after-write to the same address returns the new value.

Optional Feature:
Macro SNOOPY_MEMORY_INTERVENTION_UPDATE_EN.
- Defined: on an intervention completion, snoopyData is also written to mem[addr] in the same edge, so memory becomes clean for a Modified->Shared downgrade.
- Undefined: memory is not updated on intervention; the owning cache keeps the dirty copy.

Decomposition:
- Shared busCommands package supplies the command enum (existing); no new package typedefs.
- Responder state enum and counter are local to the module.
- One sub-module, bus_memory_array: synchronous write port, combinational read, parameterised by ADDRESS_WIDTH/DATA_WIDTH, instantiated once.

Test Plan:
- Write 0xBEEF to addr 0x12 via BUS_WRITEBACK, WRITE_LATENCY=1 -> functionComplete 1 cycle after accept. Then BUS_READ of 0x12, snoopyHit=0 -> dataIn=0xBEEF after 2 cycles; functionComplete clears one cycle after readEnabled drops.
- BUS_READ addr 0x40 with snoopyHit=1; snoopyFunctionComplete pulses 3 cycles later with snoopyData=0x1234 -> dataIn=0x1234. With the macro defined, a subsequent read with no intervention also returns 0x1234; undefined, it returns the old value.
- readEnabled=1 and writeEnabled=1 with BUS_WRITEBACK, data 0x00AA at addr 0x05 -> write performed, protocolError=1 and stays 1 until reset.
- readEnabled=1 with busCommand=BUS_INVALIDATE -> no functionComplete for 10 cycles, no error.
- Accept a read with READ_LATENCY=4, deassert readEnabled after 2 cycles -> no functionComplete, back to IDLE. Separately, a write aborted the same way leaves the old memory value intact.
- Assert reset=0 in WRITE_WAIT -> functionComplete=0 and dataIn=0 immediately (async), storage not written; normal operation resumes after reset=1.

Source files
------------

// File: rtl/snoopy_bus_memory_responder_pkg.sv
// Shared bus command encoding used by the cache controllers and the memory responder.
package snoopy_bus_memory_responder_pkg;
  typedef enum logic [1:0] {
    NONE           = 2'd0,
    BUS_READ       = 2'd1,
    BUS_WRITEBACK  = 2'd2,
    BUS_INVALIDATE = 2'd3
  } busCommands;
endpackage

// File: rtl/snoopy_bus_memory_responder_bus_memory_array.sv
// Backing word storage: synchronous write, combinational read on a single address.
module bus_memory_array #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clock,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic [DATA_WIDTH-1:0]    o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDRESS_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/snoopy_bus_memory_responder.sv
// Bus memory slave with cache-to-cache intervention on snoop hits.
// Macro SNOOPY_MEMORY_INTERVENTION_UPDATE_EN: intervention data is also written back to memory.
module snoopy_bus_memory_responder
  import snoopy_bus_memory_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int LATENCY_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  busCommands               busCommand,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    dataOut,
  input  logic                     readEnabled,
  input  logic                     writeEnabled,
  output logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     functionComplete,
  input  logic                     snoopyHit,
  input  logic                     snoopyFunctionComplete,
  input  logic [DATA_WIDTH-1:0]    snoopyData,
  output logic                     protocolError
);
  typedef enum logic [2:0] {
    S_IDLE, S_READ_WAIT, S_SNOOP_WAIT, S_WRITE_WAIT, S_COMPLETE
  } state_t;

  localparam logic [LATENCY_WIDTH-1:0] RD_LAST = LATENCY_WIDTH'(READ_LATENCY - 1);
  localparam logic [LATENCY_WIDTH-1:0] WR_LAST = LATENCY_WIDTH'(WRITE_LATENCY - 1);

  state_t                   r_state;
  logic [LATENCY_WIDTH-1:0] r_cnt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     w_we;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [DATA_WIDTH-1:0]    w_rdata;

  // Storage writes land on the same edge that raises functionComplete.
  always_comb begin
    w_we    = 1'b0;
    w_wdata = r_data;
    if (r_state == S_WRITE_WAIT && writeEnabled && r_cnt == WR_LAST) w_we = 1'b1;
`ifdef SNOOPY_MEMORY_INTERVENTION_UPDATE_EN
    if (r_state == S_SNOOP_WAIT && readEnabled && snoopyFunctionComplete) begin
      w_we    = 1'b1;
      w_wdata = snoopyData;
    end
`else
`endif
  end

  bus_memory_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_mem (
    .clock  (clock),
    .i_we   (w_we),
    .i_addr (r_addr),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_addr           <= '0;
      r_data           <= '0;
      dataIn           <= '0;
      functionComplete <= 1'b0;
      protocolError    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (readEnabled && writeEnabled &&
              (busCommand == BUS_READ || busCommand == BUS_WRITEBACK))
            protocolError <= 1'b1;
          if (writeEnabled && busCommand == BUS_WRITEBACK) begin
            r_addr  <= address;
            r_data  <= dataOut;
            r_cnt   <= '0;
            r_state <= S_WRITE_WAIT;
          end else if (readEnabled && busCommand == BUS_READ) begin
            r_addr  <= address;
            r_cnt   <= '0;
            r_state <= snoopyHit ? S_SNOOP_WAIT : S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (!readEnabled) r_state <= S_IDLE;
          else if (snoopyHit) r_state <= S_SNOOP_WAIT;
          else if (r_cnt == RD_LAST) begin
            dataIn           <= w_rdata;
            functionComplete <= 1'b1;
            r_state          <= S_COMPLETE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_SNOOP_WAIT: begin
          if (!readEnabled) r_state <= S_IDLE;
          else if (snoopyFunctionComplete) begin
            dataIn           <= snoopyData;
            functionComplete <= 1'b1;
            r_state          <= S_COMPLETE;
          end else if (!snoopyHit) begin
            r_cnt   <= '0;
            r_state <= S_READ_WAIT;
          end
        end
        S_WRITE_WAIT: begin
          if (!writeEnabled) r_state <= S_IDLE;
          else if (r_cnt == WR_LAST) begin
            functionComplete <= 1'b1;
            r_state          <= S_COMPLETE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_COMPLETE: begin
          if (!readEnabled && !writeEnabled) begin
            functionComplete <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snoopy_bus_memory_responder.sv
// Randomized and directed bench for snoopy_bus_memory_responder against a word-array model.
module tb_snoopy_bus_memory_responder;
  import snoopy_bus_memory_responder_pkg::*;

  localparam int RL = 2;
  localparam int WL = 1;

  logic        clock, reset;
  busCommands  busCommand;
  logic [7:0]  address;
  logic [15:0] dataOut, dataIn, snoopyData;
  logic        readEnabled, writeEnabled, functionComplete;
  logic        snoopyHit, snoopyFunctionComplete, protocolError;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem_model [256];
  int written[$];

  snoopy_bus_memory_responder #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(RL),
    .WRITE_LATENCY(WL), .LATENCY_WIDTH(4)
  ) dut (
    .clock(clock), .reset(reset), .busCommand(busCommand), .address(address),
    .dataOut(dataOut), .readEnabled(readEnabled), .writeEnabled(writeEnabled),
    .dataIn(dataIn), .functionComplete(functionComplete), .snoopyHit(snoopyHit),
    .snoopyFunctionComplete(snoopyFunctionComplete), .snoopyData(snoopyData),
    .protocolError(protocolError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle_bus();
    busCommand = NONE; readEnabled = 0; writeEnabled = 0;
    snoopyHit = 0; snoopyFunctionComplete = 0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d, input bit scramble);
    int cyc;
    busCommand = BUS_WRITEBACK; address = a; dataOut = d; writeEnabled = 1;
    step();
    if (scramble) begin address = 8'($urandom); dataOut = 16'($urandom); end
    cyc = 1;
    while (!functionComplete && cyc < 20) begin step(); cyc++; end
    checks++;
    if (cyc != WL + 1) begin
      errors++; $display("FAIL wr_latency a=%0h: got %0d want %0d", a, cyc, WL + 1);
    end
    mem_model[a] = d;
    if (!written.size() || !(a inside {written})) written.push_back(int'(a));
    step();
    checks++;
    if (functionComplete !== 1'b1) begin
      errors++; $display("FAIL wr_hold: got %b want 1", functionComplete);
    end
    idle_bus();
    step();
    checks++;
    if (functionComplete !== 1'b0) begin
      errors++; $display("FAIL wr_release: got %b want 0", functionComplete);
    end
  endtask

  task automatic bus_read(input logic [7:0] a, input bit scramble);
    int cyc;
    busCommand = BUS_READ; address = a; readEnabled = 1; snoopyHit = 0;
    step();
    if (scramble) address = 8'($urandom);
    cyc = 1;
    while (!functionComplete && cyc < 20) begin step(); cyc++; end
    checks++;
    if (cyc != RL + 1) begin
      errors++; $display("FAIL rd_latency a=%0h: got %0d want %0d", a, cyc, RL + 1);
    end
    checks++;
    if (dataIn !== mem_model[a]) begin
      errors++; $display("FAIL rd_data a=%0h: got %0h want %0h", a, dataIn, mem_model[a]);
    end
    step();
    checks++;
    if (functionComplete !== 1'b1 || dataIn !== mem_model[a]) begin
      errors++; $display("FAIL rd_hold: got fc=%b d=%0h want fc=1 d=%0h", functionComplete, dataIn, mem_model[a]);
    end
    idle_bus();
    step();
    checks++;
    if (functionComplete !== 1'b0) begin
      errors++; $display("FAIL rd_release: got %b want 0", functionComplete);
    end
  endtask

  task automatic snoop_read(input logic [7:0] a, input int k, input logic [15:0] sd);
    bit early;
    busCommand = BUS_READ; address = a; readEnabled = 1; snoopyHit = 1;
    step();
    early = 0;
    for (int i = 0; i < k; i++) begin
      step();
      if (functionComplete !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL snoop_wait: got early completion want none");
    end
    snoopyFunctionComplete = 1; snoopyData = sd;
    step();
    checks++;
    if (functionComplete !== 1'b1 || dataIn !== sd) begin
      errors++; $display("FAIL snoop_data a=%0h: got fc=%b d=%0h want fc=1 d=%0h", a, functionComplete, dataIn, sd);
    end
`ifdef SNOOPY_MEMORY_INTERVENTION_UPDATE_EN
    mem_model[a] = sd;
    if (!(a inside {written})) written.push_back(int'(a));
`else
`endif
    snoopyFunctionComplete = 0; snoopyData = 16'($urandom);
    idle_bus();
    step();
    checks++;
    if (functionComplete !== 1'b0) begin
      errors++; $display("FAIL snoop_release: got %b want 0", functionComplete);
    end
  endtask

  task automatic test_reset();
    idle_bus(); address = 0; dataOut = 0; snoopyData = 0;
    reset = 1; #3; reset = 0; #1;
    checks++;
    if (functionComplete !== 1'b0 || dataIn !== 16'h0 || protocolError !== 1'b0) begin
      errors++; $display("FAIL reset_state: got fc=%b d=%0h err=%b want 0/0/0", functionComplete, dataIn, protocolError);
    end
    repeat (2) @(negedge clock);
    reset = 1;
    step();
  endtask

  task automatic test_write_read();
    bus_write(8'h12, 16'hBEEF, 1'b0);
    bus_read(8'h12, 1'b0);
    bus_write(8'h13, 16'h7001, 1'b1);
    bus_read(8'h13, 1'b1);
    bus_read(8'h12, 1'b0);
  endtask

  task automatic test_intervention();
    bus_write(8'h40, 16'h5555, 1'b0);
    snoop_read(8'h40, 3, 16'h1234);
    bus_read(8'h40, 1'b0);
  endtask

  task automatic test_snoop_fallback();
    int cyc;
    busCommand = BUS_READ; address = 8'h12; readEnabled = 1; snoopyHit = 1;
    step(); step();
    snoopyHit = 0;
    cyc = 1;
    step();
    while (!functionComplete && cyc < 20) begin step(); cyc++; end
    checks++;
    if (cyc != RL + 1 || dataIn !== mem_model[8'h12]) begin
      errors++; $display("FAIL snoop_fallback: got cyc=%0d d=%0h want cyc=%0d d=%0h", cyc, dataIn, RL + 1, mem_model[8'h12]);
    end
    idle_bus(); step();
  endtask

  task automatic test_ignored_cmds();
    bit bad;
    bad = 0;
    busCommand = BUS_INVALIDATE; address = 8'h12; readEnabled = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (functionComplete !== 1'b0 || protocolError !== 1'b0) bad = 1;
    end
    busCommand = NONE; readEnabled = 0; writeEnabled = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (functionComplete !== 1'b0 || protocolError !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL ignored_cmd: got completion or error want none");
    end
    idle_bus(); step();
  endtask

  task automatic test_abort();
    bit bad;
    bus_write(8'h20, 16'h0A0A, 1'b0);
    bad = 0;
    busCommand = BUS_READ; address = 8'h20; readEnabled = 1;
    step();
    readEnabled = 0; busCommand = NONE;
    for (int i = 0; i < 5; i++) begin
      step();
      if (functionComplete !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL read_abort: got completion want none");
    end
    bad = 0;
    busCommand = BUS_WRITEBACK; address = 8'h20; dataOut = 16'hDEAD; writeEnabled = 1;
    step();
    writeEnabled = 0; busCommand = NONE;
    for (int i = 0; i < 5; i++) begin
      step();
      if (functionComplete !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL write_abort: got completion want none");
    end
    bus_read(8'h20, 1'b0);
  endtask

  task automatic test_protocol_error();
    int cyc;
    checks++;
    if (protocolError !== 1'b0) begin
      errors++; $display("FAIL err_before: got %b want 0", protocolError);
    end
    busCommand = BUS_WRITEBACK; address = 8'h05; dataOut = 16'h00AA;
    readEnabled = 1; writeEnabled = 1;
    step();
    cyc = 1;
    while (!functionComplete && cyc < 20) begin step(); cyc++; end
    checks++;
    if (cyc != WL + 1 || protocolError !== 1'b1) begin
      errors++; $display("FAIL err_write: got cyc=%0d err=%b want cyc=%0d err=1", cyc, protocolError, WL + 1);
    end
    mem_model[8'h05] = 16'h00AA;
    written.push_back(5);
    idle_bus(); step();
    bus_read(8'h05, 1'b0);
    checks++;
    if (protocolError !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", protocolError);
    end
  endtask

  task automatic test_reset_midwrite();
    bus_read(8'h12, 1'b0);
    busCommand = BUS_WRITEBACK; address = 8'h12; dataOut = 16'h0F0F; writeEnabled = 1;
    step();
    reset = 0; #1;
    checks++;
    if (functionComplete !== 1'b0 || dataIn !== 16'h0 || protocolError !== 1'b0) begin
      errors++; $display("FAIL reset_async: got fc=%b d=%0h err=%b want 0/0/0", functionComplete, dataIn, protocolError);
    end
    idle_bus();
    repeat (3) @(negedge clock);
    reset = 1;
    step();
    bus_read(8'h12, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [7:0] a;
      op = (written.size() == 0) ? 0 : int'($urandom_range(0, 2));
      if (op == 0) begin
        a = 8'($urandom);
        bus_write(a, 16'($urandom), 1'b1);
      end else begin
        a = 8'(written[$urandom_range(0, written.size() - 1)]);
        if (op == 1) bus_read(a, 1'b1);
        else snoop_read(a, int'($urandom_range(0, 4)), 16'($urandom));
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_intervention();
    test_snoop_fallback();
    test_ignored_cmds();
    test_abort();
    test_protocol_error();
    test_reset_midwrite();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
